// File: rtl/ptri_check.sv
// Point-in-triangle checker: one shared doubled-area datapath evaluates four areas
// serially, then compares A1 against A2+A3+A4. Define PTRI_AREA_OUT_EN to expose o_area1.
module ptri_check (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [11:0] p1x,
  input  logic [11:0] p1y,
  input  logic [11:0] p2x,
  input  logic [11:0] p2y,
  input  logic [11:0] p3x,
  input  logic [11:0] p3y,
  input  logic [11:0] ptx,
  input  logic [11:0] pty,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_inside,
`ifdef PTRI_AREA_OUT_EN
  output logic        o_degen,
  output logic [26:0] o_area1
`else
  output logic        o_degen
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, CMP, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  k;
  logic [11:0] c_p1x, c_p1y, c_p2x, c_p2y, c_p3x, c_p3y, c_ptx, c_pty;
  logic [26:0] a1, a2, a3, a4;
  logic        accept;

  logic [11:0]        ax, ay, bx, by, cx, cy;
  logic signed [12:0] d_bc, d_ca, d_ab;
  logic signed [25:0] t_a, t_b, t_c;
  logic signed [27:0] area_sum;
  logic [26:0]        area_abs;
  logic [27:0]        part_sum;
  logic               degen_now;

  assign accept = (state == IDLE) && i_valid;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = CALC;
      end
      CALC: if (k == 2'd3) state_nxt = CMP;
      CMP:  state_nxt = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand selection for the shared area unit, one triangle per CALC cycle
  always_comb begin
    ax = c_p1x; ay = c_p1y;
    bx = c_p2x; by = c_p2y;
    cx = c_p3x; cy = c_p3y;
    case (k)
      2'd0: ;
      2'd1: begin cx = c_ptx; cy = c_pty; end
      2'd2: begin
        ax = c_p2x; ay = c_p2y;
        bx = c_p3x; by = c_p3y;
        cx = c_ptx; cy = c_pty;
      end
      default: begin
        ax = c_p3x; ay = c_p3y;
        bx = c_p1x; by = c_p1y;
        cx = c_ptx; cy = c_pty;
      end
    endcase
  end

  always_comb begin
    d_bc     = $signed({1'b0, by}) - $signed({1'b0, cy});
    d_ca     = $signed({1'b0, cy}) - $signed({1'b0, ay});
    d_ab     = $signed({1'b0, ay}) - $signed({1'b0, by});
    t_a      = $signed({1'b0, ax}) * d_bc;
    t_b      = $signed({1'b0, bx}) * d_ca;
    t_c      = $signed({1'b0, cx}) * d_ab;
    area_sum = {{2{t_a[25]}}, t_a} + {{2{t_b[25]}}, t_b} + {{2{t_c[25]}}, t_c};
    area_abs = area_sum[27] ? 27'(-area_sum) : 27'(area_sum);
  end

  assign part_sum  = {1'b0, a2} + {1'b0, a3} + {1'b0, a4};
  assign degen_now = (a1 == '0);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      k     <= '0;
      c_p1x <= '0; c_p1y <= '0;
      c_p2x <= '0; c_p2y <= '0;
      c_p3x <= '0; c_p3y <= '0;
      c_ptx <= '0; c_pty <= '0;
      a1    <= '0; a2 <= '0; a3 <= '0; a4 <= '0;
    end else begin
      if (accept) begin
        k     <= '0;
        c_p1x <= p1x; c_p1y <= p1y;
        c_p2x <= p2x; c_p2y <= p2y;
        c_p3x <= p3x; c_p3y <= p3y;
        c_ptx <= ptx; c_pty <= pty;
      end else if (state == CALC) begin
        k <= k + 2'd1;
        case (k)
          2'd0:    a1 <= area_abs;
          2'd1:    a2 <= area_abs;
          2'd2:    a3 <= area_abs;
          default: a4 <= area_abs;
        endcase
      end
    end
  end

  // Result flags are only written on the CMP cycle and otherwise hold their last value
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_inside <= 1'b0;
      o_degen  <= 1'b0;
    end else if (state == CMP) begin
      o_degen  <= degen_now;
      o_inside <= !degen_now && ({1'b0, a1} == part_sum);
    end
  end

`ifdef PTRI_AREA_OUT_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)            o_area1 <= '0;
    else if (state == CMP)  o_area1 <= a1;
  end
`endif

endmodule

// File: tb/tb_ptri_check.sv
// Directed bench for ptri_check: hand-computed triangle cases, hold/backpressure,
// mid-job reset and max-coordinate vectors. Checks o_area1 when PTRI_AREA_OUT_EN is defined.
module tb_ptri_check;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [11:0] p1x, p1y, p2x, p2y, p3x, p3y, ptx, pty;
  logic        o_valid;
  logic        i_ready;
  logic        o_inside;
  logic        o_degen;
`ifdef PTRI_AREA_OUT_EN
  logic [26:0] o_area1;
`endif

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  always #5 i_clock = ~i_clock;

  ptri_check dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .p1x      (p1x),
    .p1y      (p1y),
    .p2x      (p2x),
    .p2y      (p2y),
    .p3x      (p3x),
    .p3y      (p3y),
    .ptx      (ptx),
    .pty      (pty),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_inside (o_inside),
`ifdef PTRI_AREA_OUT_EN
    .o_degen  (o_degen),
    .o_area1  (o_area1)
`else
    .o_degen  (o_degen)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_job(input int x1, input int y1, input int x2, input int y2,
                         input int x3, input int y3, input int xt, input int yt);
    p1x = 12'(x1); p1y = 12'(y1);
    p2x = 12'(x2); p2y = 12'(y2);
    p3x = 12'(x3); p3y = 12'(y3);
    ptx = 12'(xt); pty = 12'(yt);
  endtask

  task automatic scramble();
    p1x = 12'($urandom); p1y = 12'($urandom);
    p2x = 12'($urandom); p2y = 12'($urandom);
    p3x = 12'($urandom); p3y = 12'($urandom);
    ptx = 12'($urandom); pty = 12'($urandom);
  endtask

  // Called at the negedge just after the accept edge; returns at the negedge where o_valid is seen.
  task automatic wait_result(input string tag, input int exp_in, input int exp_dg, input int exp_area);
    int n;
    n = 0;
    while (o_valid !== 1'b1 && n < 20) begin
      @(posedge i_clock);
      @(negedge i_clock);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd5);
    check({tag, "_inside"}, {31'd0, o_inside}, 32'(exp_in));
    check({tag, "_degen"},  {31'd0, o_degen},  32'(exp_dg));
`ifdef PTRI_AREA_OUT_EN
    check({tag, "_area1"}, {5'd0, o_area1}, 32'(exp_area));
`else
    if (exp_area < 0) $display("unexpected negative area for %s", tag);
`endif
  endtask

  // Starts at a negedge with inputs already set; offers, accepts, scrambles inputs.
  task automatic offer_and_accept(input string tag);
    i_valid = 1'b1;
    check({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    @(posedge i_clock);
    @(negedge i_clock);
    i_valid = 1'b0;
    scramble();
  endtask

  task automatic consume(input string tag);
    i_ready = 1'b1;
    @(posedge i_clock);
    @(negedge i_clock);
    i_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, o_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, o_ready}, 32'd1);
  endtask

  task automatic run_job(input string tag, input int x1, input int y1, input int x2, input int y2,
                         input int x3, input int y3, input int xt, input int yt,
                         input int exp_in, input int exp_dg, input int exp_area);
    @(negedge i_clock);
    set_job(x1, y1, x2, y2, x3, y3, xt, yt);
    offer_and_accept(tag);
    wait_result(tag, exp_in, exp_dg, exp_area);
  endtask

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    set_job(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst_valid",  {31'd0, o_valid},  32'd0);
    check("rst_inside", {31'd0, o_inside}, 32'd0);
    check("rst_degen",  {31'd0, o_degen},  32'd0);
`ifdef PTRI_AREA_OUT_EN
    check("rst_area1", {5'd0, o_area1}, 32'd0);
`endif
    @(negedge i_clock);
    i_reset = 1'b0;
    @(negedge i_clock);
    check("rst_ready", {31'd0, o_ready}, 32'd1);

    // Outside point, then held result with extra offers ignored
    run_job("outside", 2, 23, 1, 25, 6, 25, 5, 23, 0, 0, 10);
    set_job(2, 23, 1, 25, 6, 25, 3, 24);
    i_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clock);
      @(negedge i_clock);
      check("hold_valid",  {31'd0, o_valid},  32'd1);
      check("hold_ready",  {31'd0, o_ready},  32'd0);
      check("hold_inside", {31'd0, o_inside}, 32'd0);
      check("hold_degen",  {31'd0, o_degen},  32'd0);
    end
    // i_valid stays high across the consume edge: must not be taken that cycle
    consume("hold");
    check("idle_keeps_inside", {31'd0, o_inside}, 32'd0);
    @(posedge i_clock);
    @(negedge i_clock);
    i_valid = 1'b0;
    scramble();
    check("busy_ready", {31'd0, o_ready}, 32'd0);
    wait_result("inside", 1, 0, 10);
    consume("inside");

    run_job("vertex", 2, 23, 1, 25, 6, 25, 2, 23, 1, 0, 10);
    consume("vertex");
    run_job("collinear", 0, 0, 1, 1, 2, 2, 1, 1, 0, 1, 0);
    consume("collinear");
    run_job("max_in", 0, 0, 4095, 0, 0, 4095, 0, 0, 1, 0, 16769025);
    consume("max_in");
    run_job("max_out", 0, 0, 4095, 0, 0, 4095, 4095, 4095, 0, 0, 16769025);
    consume("max_out");

    // Reset while k=2: previous result was inside=1, so the clear is observable
    run_job("pre_rst", 2, 23, 1, 25, 6, 25, 3, 24, 1, 0, 10);
    consume("pre_rst");
    @(negedge i_clock);
    set_job(2, 23, 1, 25, 6, 25, 5, 23);
    offer_and_accept("abort");
    @(posedge i_clock);
    @(posedge i_clock);
    #2;
    i_reset = 1'b1;
    #1;
    check("abort_valid",  {31'd0, o_valid},  32'd0);
    check("abort_inside", {31'd0, o_inside}, 32'd0);
    check("abort_degen",  {31'd0, o_degen},  32'd0);
    @(negedge i_clock);
    i_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge i_clock);
      @(negedge i_clock);
      check("abort_no_result", {31'd0, o_valid}, 32'd0);
    end
    run_job("post_rst", 2, 23, 1, 25, 6, 25, 3, 24, 1, 0, 10);
    consume("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ptri_check.md
PTRI_CHECK -- requirements
Module: ptri_check

Interface
REQ-001 SHALL have ports: i_clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: i_reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: i_valid  in  1  job offered; o_ready  out  1  job accepted when i_valid&&o_ready at a rising edge.
REQ-004 SHALL have ports: p1x,p1y,p2x,p2y,p3x,p3y,ptx,pty  in  12 each  unsigned triangle vertices and test point.
REQ-005 SHALL have ports: o_valid  out  1  result held; i_ready  in  1  result consumed when o_valid&&i_ready at a rising edge.
REQ-006 SHALL have ports: o_inside  out  1  test point inside or on the triangle; o_degen  out  1  triangle area zero.
REQ-007 SHALL have port o_area1  out  27  doubled area of p1,p2,p3, present only under PTRI_AREA_OUT_EN (REQ-023).

Function
REQ-008 SHALL register all eight coordinates on the accept edge (E0); input changes afterwards SHALL not affect the job.
REQ-009 SHALL use one shared doubled-area datapath: D(a,b,c) = |ax(by-cy) + bx(cy-ay) + cx(ay-by)|.
REQ-010 Widths: coordinate differences 13-bit signed; products 26-bit signed (x zero-extended); three-term sum 28-bit signed; D 27-bit unsigned; no truncation.
REQ-011 FSM states: IDLE, CALC, CMP, DONE; o_ready=1 only in IDLE.
REQ-012 IDLE -> CALC on accept; CALC runs exactly 4 cycles with 2-bit index k = 0..3, one D per edge E1..E4: A1=D(p1,p2,p3), A2=D(p1,p2,pt), A3=D(p2,p3,pt), A4=D(p3,p1,pt).
REQ-013 CALC -> CMP after k=3 (no wrap into k=0 of a new job); CMP evaluates at E5 and enters DONE.
REQ-014 At E5: o_degen = (A1==0); o_inside = !o_degen && (A1 == A2+A3+A4), sum taken at 28 bits unsigned.
REQ-015 o_valid SHALL rise after E5 (latency 5 cycles from accept) and hold with o_inside/o_degen stable until consumed.
REQ-016 DONE -> IDLE on the edge where i_ready=1; o_valid low the following cycle; o_ready high the same cycle.
REQ-017 A new job SHALL not be accepted in the cycle the previous result is consumed; minimum spacing between accepts is 7 cycles.
REQ-018 i_valid while not in IDLE SHALL be ignored; no queueing.
REQ-019 o_inside/o_degen SHALL keep last values in IDLE/CALC/CMP; only o_valid qualifies them.
REQ-020 Points on an edge or vertex SHALL report o_inside=1 (exact equality, no tolerance).

Reset
REQ-021 On i_reset=1, immediately: state IDLE, k=0, o_valid=0, o_inside=0, o_degen=0, o_area1=0, captured coordinates and A1..A4 = 0; o_ready=1 after release.
REQ-022 Reset during CALC, CMP or DONE SHALL abort the job with no result emitted.

Configuration
REQ-023 Macro PTRI_AREA_OUT_EN: when defined, o_area1 is present and loaded with A1 at E5, held like o_inside; when undefined, the port and its register are absent and all other behaviour is identical.

Verification
REQ-024 Tri (2,23),(1,25),(6,25), pt (5,23) -> A1=10, A2=6, A3=10, A4=6; o_valid after 5 cycles, o_inside=0, o_degen=0, o_area1=10.
REQ-025 Same tri, pt (3,24) -> A2=3, A3=5, A4=2, sum 10; o_inside=1.
REQ-026 Same tri, pt (2,23) (vertex) -> o_inside=1; collinear (0,0),(1,1),(2,2), pt (1,1) -> o_degen=1, o_inside=0.
REQ-027 Hold i_ready=0 for 10 cycles after o_valid -> outputs stable, o_ready=0, extra i_valid ignored; i_ready=1 -> o_valid falls next cycle, next job accepted no earlier than one cycle later.
REQ-028 Assert i_reset during CALC at k=2 -> outputs 0 immediately, no o_valid; the next job returns the correct result.
REQ-029 Max coordinates (0,0),(4095,0),(0,4095), pt (0,0) -> A1=16769025, no overflow, o_inside=1.
